// File: rtl/fpmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier using a shift-add mantissa datapath.
// Shares DONE/EXCEPTION/BUSY conventions with the sequential divider.
module fpmul_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic [EXP_W+MANT_W:0]     InputA,
    input  logic [EXP_W+MANT_W:0]     InputB,
    output logic [EXP_W+MANT_W:0]     AxB,
    output logic                      DONE,
    output logic [1:0]                EXCEPTION,
    output logic                      BUSY
);

    localparam int W   = 1 + EXP_W + MANT_W;
    localparam int MW  = MANT_W + 1;
    localparam int PW  = 2 * MW;
    localparam int EW2 = EXP_W + 2;
    localparam int CW  = $clog2(MW);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, (MANT_W-1)'(0)};

    typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, FIN} stateT;

    stateT               state, stateNext;
    logic [W-1:0]        opA, opB;
    logic [MW-1:0]       ma, mb;
    logic [PW-1:0]       prod, prodStep;
    logic [CW-1:0]       count;

    logic                signRes;
    logic [EXP_W-1:0]    expA, expB;
    logic [MANT_W-1:0]   mantA, mantB;
    logic                aZero, bZero, aInf, bInf, aNan, bNan;
    logic                isInvalid, isInf, isZero, isSpecial;
    logic signed [EW2-1:0] expSum, expAdj;
    logic [MANT_W-1:0]   mantNorm;

    assign signRes = opA[W-1] ^ opB[W-1];
    assign expA    = opA[W-2:MANT_W];
    assign expB    = opB[W-2:MANT_W];
    assign mantA   = opA[MANT_W-1:0];
    assign mantB   = opB[MANT_W-1:0];

    // Subnormals count as zero, so a zero exponent alone marks a zero operand.
    assign aZero = (expA == '0);
    assign bZero = (expB == '0);
    assign aInf  = (expA == EXP_MAX) && (mantA == '0);
    assign bInf  = (expB == EXP_MAX) && (mantB == '0);
    assign aNan  = (expA == EXP_MAX) && (mantA != '0);
    assign bNan  = (expB == EXP_MAX) && (mantB != '0);

    assign isInvalid = aNan || bNan || (aZero && bInf) || (aInf && bZero);
    assign isInf     = aInf || bInf;
    assign isZero    = aZero || bZero;
    assign isSpecial = isInvalid || isInf || isZero;

    // One shift-add step: add ma into the upper half when the current multiplier bit is set.
    assign prodStep = PW'(({1'b0, prod} + {1'b0, (mb[0] ? ma : MW'(0)), MW'(0)}) >> 1);

    assign expSum   = $signed({2'b00, expA}) + $signed({2'b00, expB}) - $signed(EW2'(BIAS));
    assign expAdj   = prod[PW-1] ? expSum + $signed(EW2'(1)) : expSum;
    assign mantNorm = prod[PW-1] ? prod[PW-2:MW] : prod[PW-3:MW-1];

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (START) stateNext = CHECK;
            CHECK:   stateNext = isSpecial ? FIN : MUL;
            MUL:     if (count == '0) stateNext = NORM;
            NORM:    stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and result registers; results are truncated toward zero like the divider.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            opA       <= '0;
            opB       <= '0;
            ma        <= '0;
            mb        <= '0;
            prod      <= '0;
            count     <= '0;
            AxB       <= '0;
            DONE      <= 1'b0;
            EXCEPTION <= 2'b00;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        opA  <= InputA;
                        opB  <= InputB;
                        BUSY <= 1'b1;
                        DONE <= 1'b0;
                    end
                end
                CHECK: begin
                    if (isInvalid) begin
                        AxB       <= QNAN;
                        EXCEPTION <= 2'b11;
                    end else if (isInf) begin
                        AxB       <= {signRes, EXP_MAX, MANT_W'(0)};
                        EXCEPTION <= 2'b00;
                    end else if (isZero) begin
                        AxB       <= {signRes, (W-1)'(0)};
                        EXCEPTION <= 2'b00;
                    end else begin
                        ma    <= {1'b1, mantA};
                        mb    <= {1'b1, mantB};
                        prod  <= '0;
                        count <= CW'(MW - 1);
                    end
                end
                MUL: begin
                    prod <= prodStep;
                    mb   <= mb >> 1;
                    if (count != '0) count <= count - 1'b1;
                end
                NORM: begin
                    if (expAdj >= $signed({2'b00, EXP_MAX})) begin
                        AxB       <= {signRes, EXP_MAX, MANT_W'(0)};
                        EXCEPTION <= 2'b01;
                    end else if (expAdj[EW2-1] || expAdj == '0) begin
                        AxB       <= {signRes, (W-1)'(0)};
                        EXCEPTION <= 2'b10;
                    end else begin
                        AxB       <= {signRes, expAdj[EXP_W-1:0], mantNorm};
                        EXCEPTION <= 2'b00;
                    end
                end
                FIN: begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_seq.sv
// Scoreboard testbench for fpmul_seq: expected results are queued at START and popped at DONE.
module tb_fpmul_seq;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] InputA, InputB;
    logic [31:0] AxB;
    logic        DONE;
    logic [1:0]  EXCEPTION;
    logic        BUSY;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  exc;
        logic [5:0]  lat;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    fpmul_seq dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .InputA(InputA), .InputB(InputB),
        .AxB(AxB), .DONE(DONE), .EXCEPTION(EXCEPTION), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model built on a plain multiply rather than a shift-add loop.
    function automatic expT model(input logic [31:0] a, input logic [31:0] b);
        expT         r;
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        bit aZ, bZ, aI, bI, aN, bN;
        s  = a[31] ^ b[31];
        aZ = (a[30:23] == 8'h00);
        bZ = (b[30:23] == 8'h00);
        aI = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bI = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        aN = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bN = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        r.lat = 6'd2;
        if (aN || bN || (aZ && bI) || (aI && bZ)) begin
            r.res = 32'h7FC00000; r.exc = 2'b11;
        end else if (aI || bI) begin
            r.res = {s, 8'hFF, 23'd0}; r.exc = 2'b00;
        end else if (aZ || bZ) begin
            r.res = {s, 31'd0}; r.exc = 2'b00;
        end else begin
            r.lat = 6'd27;
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p[47]) begin m = p[46:24]; e = e + 1; end
            else m = p[45:23];
            if (e >= 255)    begin r.res = {s, 8'hFF, 23'd0}; r.exc = 2'b01; end
            else if (e <= 0) begin r.res = {s, 31'd0};        r.exc = 2'b10; end
            else             begin r.res = {s, e[7:0], m};    r.exc = 2'b00; end
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge CLOCK);
        InputA = a;
        InputB = b;
        START  = 1'b1;
        sb.push_back(model(a, b));
        @(negedge CLOCK);
        START  = 1'b0;
    endtask

    task automatic waitDone(inout int cycles);
        do begin
            @(negedge CLOCK);
            cycles++;
        end while (!DONE && cycles < 60);
    endtask

    task automatic popExp(output expT e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; InputA = '0; InputB = '0;
        #12;
        checks++;
        if ({AxB, DONE, EXCEPTION, BUSY} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got AxB=%h DONE=%b EXC=%b BUSY=%b, expected all zero", AxB, DONE, EXCEPTION, BUSY);
        end
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    task automatic test_vectors(input string name, input logic [31:0] va[], input logic [31:0] vb[]);
        expT e;
        int  cyc;
        for (int i = 0; i < va.size(); i++) begin
            issue(va[i], vb[i]);
            checks++;
            if (BUSY !== 1'b1 || DONE !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_accept[%0d]: got BUSY=%b DONE=%b, expected BUSY=1 DONE=0", name, i, BUSY, DONE);
            end
            cyc = 0;
            waitDone(cyc);
            popExp(e);
            checks++;
            if (AxB !== e.res || EXCEPTION !== e.exc) begin
                errors++;
                $display("[TB] FAIL %s_result[%0d] %h*%h: got %h/%b, expected %h/%b", name, i, va[i], vb[i], AxB, EXCEPTION, e.res, e.exc);
            end
            checks++;
            if (cyc != int'(e.lat) || BUSY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_latency[%0d]: got %0d cycles BUSY=%b, expected %0d cycles BUSY=0", name, i, cyc, BUSY, e.lat);
            end
        end
    endtask

    task automatic test_arith;
        logic [31:0] a[] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h7F000000, 32'h00800000,
                             32'h3F800000, 32'h3FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] b[] = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h40000000, 32'h3F000000,
                             32'hBF800000, 32'h3FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        // Tail entries are random operands; the model covers whatever class they land in.
        for (int i = 7; i < a.size(); i++) begin
            a[i] = {$urandom_range(1, 0), 8'($urandom_range(100, 154)), 23'($urandom)};
            b[i] = {$urandom_range(1, 0), 8'($urandom_range(100, 154)), 23'($urandom)};
        end
        test_vectors("arith", a, b);
    endtask

    task automatic test_specials;
        logic [31:0] a[] = '{32'h00000000, 32'h80000000, 32'h7FC00001, 32'hFF800000, 32'h7F800000, 32'h00012345, 32'h3F800000};
        logic [31:0] b[] = '{32'h7F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'hFF800000, 32'h40000000, 32'h7F800001};
        test_vectors("special", a, b);
    endtask

    task automatic test_busy_ignore;
        expT e;
        int  cyc;
        issue(32'h3FC00000, 32'h40400000);
        cyc = 0;
        repeat (4) begin @(negedge CLOCK); cyc++; end
        InputA = 32'h7F000000; InputB = 32'h40000000; START = 1'b1;
        @(negedge CLOCK); cyc++;
        START = 1'b0;
        waitDone(cyc);
        popExp(e);
        checks++;
        if (AxB !== 32'h40900000 || EXCEPTION !== 2'b00 || cyc != 27) begin
            errors++;
            $display("[TB] FAIL busy_ignore: got %h/%b after %0d cycles, expected 40900000/00 after 27", AxB, EXCEPTION, cyc);
        end
        repeat (3) @(negedge CLOCK);
        checks++;
        if (DONE !== 1'b1 || AxB !== e.res) begin
            errors++;
            $display("[TB] FAIL done_hold: got DONE=%b AxB=%h, expected DONE=1 AxB=%h", DONE, AxB, e.res);
        end
    endtask

    task automatic test_reset_abort;
        expT e;
        int  cyc;
        issue(32'h40000000, 32'h40400000);
        repeat (9) @(negedge CLOCK);
        #2 RESET = 1'b1;
        #1;
        popExp(e);
        checks++;
        if (DONE !== 1'b0 || AxB !== 32'd0 || BUSY !== 1'b0 || EXCEPTION !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_abort: got DONE=%b AxB=%h BUSY=%b EXC=%b, expected all zero", DONE, AxB, BUSY, EXCEPTION);
        end
        @(negedge CLOCK);
        RESET = 1'b0;
        issue(32'h40400000, 32'h40400000);
        cyc = 0;
        waitDone(cyc);
        popExp(e);
        checks++;
        if (AxB !== 32'h41100000 || EXCEPTION !== 2'b00 || cyc != 27) begin
            errors++;
            $display("[TB] FAIL after_reset: got %h/%b after %0d cycles, expected 41100000/00 after 27", AxB, EXCEPTION, cyc);
        end
    endtask

    task automatic test_back_to_back;
        expT e;
        int  cyc;
        issue(32'h40000000, 32'h40400000);
        repeat (26) @(negedge CLOCK);
        InputA = 32'hC0000000; InputB = 32'h40400000; START = 1'b1;
        @(negedge CLOCK);
        popExp(e);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || AxB !== e.res) begin
            errors++;
            $display("[TB] FAIL b2b_first: got DONE=%b BUSY=%b AxB=%h, expected DONE=1 BUSY=0 AxB=%h", DONE, BUSY, AxB, e.res);
        end
        sb.push_back(model(InputA, InputB));
        @(negedge CLOCK);
        START = 1'b0;
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got DONE=%b BUSY=%b, expected DONE=0 BUSY=1", DONE, BUSY);
        end
        cyc = 0;
        waitDone(cyc);
        popExp(e);
        checks++;
        if (AxB !== e.res || EXCEPTION !== e.exc || cyc != 27) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h/%b after %0d cycles, expected %h/%b after 27", AxB, EXCEPTION, cyc, e.res, e.exc);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
